led_rate_controller: RTL and testbench
======================================

Name: led_rate_controller

Overview:
- Run-control sequencer for the PRBS LED datapath.
- Generates a one-cycle step enable that advances the PRBS generator at a programmable rate, plus a matching square-wave `clock_out` for LED blink timing.
- Supports start/stop, single-step, finite bursts and runtime divisor loading via a valid/ready handshake.
- Sits between the board control inputs and the PRBS/LED logic, replacing the fixed-divisor divider in the top level.

Parameters:
- CNT_W, 28, width of the divide counter and divisor.
- DEFAULT_DIV, 28'd4_000_000, divisor value after reset.
- BURST_W, 16, width of the burst length and step counter.

Ports:
- clock_in  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  level-sampled; begins a run from IDLE.
- stop  input  1  level-sampled; aborts a run.
- single_step  input  1  request one step from IDLE.
- div_valid  input  1  new divisor offered.
- div_value  input  CNT_W  divisor value.
- div_ready  output  1  divisor can be accepted (combinational: state==IDLE).
- burst_len  input  BURST_W  steps per run, sampled at start; 0 = run forever.
- step_out  output  1  one-cycle enable to the PRBS generator.
- clock_out  output  1  square wave of period div_reg while running.
- busy  output  1  state != IDLE.
- done  output  1  one-cycle pulse when a finite burst completes.
- step_count  output  BURST_W  steps issued since last start.

Behaviour:
- Reset (async): state=IDLE, counter=0, div_reg=DEFAULT_DIV, burst_reg=0, step_count=0, step_out=0, clock_out=0, done=0. Consequently busy=0 and div_ready=1.
- States: IDLE, RUN, STEP.
- Divisor load:
  - Occurs on an edge with div_valid && div_ready.
  - div_reg <= (div_value<2) ? 2 : div_value.
  - No load in RUN/STEP; div_valid is held off by div_ready=0 and the offered value is not consumed.
- IDLE:
  - start → RUN. Counter=0, burst_reg<=burst_len, step_count<=0.
  - Else single_step → STEP.
  - start has priority over single_step.
  - A divisor load on the same edge as start is used by the run.
- RUN:
  - Counter increments each cycle and wraps to 0 when counter==div_reg-1.
  - On that wrap edge, step_out<=1 for one cycle and step_count<=step_count+1 (wraps modulo 2^BURST_W).
  - First step_out is high exactly div_reg cycles after the start edge; steps then repeat every div_reg cycles.
- clock_out: in RUN, registered (counter < div_reg/2) (integer division); forced 0 in IDLE/STEP.
- Burst completion:
  - Applies when burst_reg!=0 and a wrap edge brings step_count to burst_reg.
  - Next state IDLE, done<=1 for one cycle, coincident with the final step_out.
  - Counter cleared.
- stop in RUN:
  - Next state IDLE, counter<=0, no done.
  - stop has priority over a coincident wrap: no step_out is issued and step_count is unchanged.
  - start while in RUN is ignored.
- STEP:
  - Lasts exactly one cycle.
  - step_out<=1, step_count<=step_count+1 (not cleared), then IDLE.
  - stop/start during STEP are ignored.
- Outputs step_out, done and clock_out are registered; there is no combinational path from inputs to them.
- Reset asserted mid-run returns everything to reset values immediately; div_reg also reverts to DEFAULT_DIV.

Test Plan:
- Reset, then start with burst_len=0, no load → first step_out after 4_000_000 cycles. Use DEFAULT_DIV=8 override: step_out at cycles 8, 16, 24; clock_out high 4 / low 4.
- Load div_value=5 in IDLE with burst_len=3 and start → div_ready=1 on load edge, then step_out at cycles 5, 10, 15. done pulses with the third step; busy falls; step_count=3.
- div_value=1 loaded → div_reg=2, step_out every 2 cycles. div_valid asserted during RUN → div_ready=0 and div_reg unchanged.
- Run with div=4, assert stop on the wrap cycle → no step_out, step_count unchanged, done=0, busy=0 next cycle.
- In IDLE pulse single_step twice → two one-cycle step_out pulses, step_count increments to 2 (from 0 after reset). Assert start+single_step together → RUN entered, no immediate step.
- Assert reset mid-run (div=6, after 2 steps) → all outputs 0 asynchronously, div_reg=DEFAULT_DIV, div_ready=1.

Source files
------------

// File: rtl/led_rate_controller.sv
// Run-control sequencer: registered one-cycle step enables and a blink square wave at a programmable divisor.
// The first step arrives div_reg cycles after start; a divisor offer is stalled by div_ready=0 whenever not IDLE.
module led_rate_controller #(
    parameter int               CNT_W       = 28,
    parameter logic [CNT_W-1:0] DEFAULT_DIV = 28'd4_000_000,
    parameter int               BURST_W     = 16
) (
    input  logic               clock_in,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic               single_step,
    input  logic               div_valid,
    input  logic [CNT_W-1:0]   div_value,
    output logic               div_ready,
    input  logic [BURST_W-1:0] burst_len,
    output logic               step_out,
    output logic               clock_out,
    output logic               busy,
    output logic               done,
    output logic [BURST_W-1:0] step_count
);

    localparam logic [CNT_W-1:0]   CNT_ONE = 1;
    localparam logic [CNT_W-1:0]   CNT_TWO = 2;
    localparam logic [BURST_W-1:0] STP_ONE = 1;

    typedef enum logic [1:0] {IDLE, RUN, STEP} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   counter, counter_nxt;
    logic [CNT_W-1:0]   div_reg;
    logic [BURST_W-1:0] burst_reg, burst_nxt;
    logic [BURST_W-1:0] step_count_nxt, step_inc;
    logic               step_nxt, done_nxt, clock_nxt;
    logic               wrap;

    assign div_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign wrap      = (counter == div_reg - CNT_ONE);
    assign step_inc  = step_count + STP_ONE;

    always_comb begin
        state_nxt      = state;
        counter_nxt    = counter;
        burst_nxt      = burst_reg;
        step_count_nxt = step_count;
        step_nxt       = 1'b0;
        done_nxt       = 1'b0;
        clock_nxt      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt      = RUN;
                    counter_nxt    = '0;
                    burst_nxt      = burst_len;
                    step_count_nxt = '0;
                end else if (single_step) begin
                    state_nxt = STEP;
                end
            end
            RUN: begin
                // stop wins over a coincident wrap, so the pending step is dropped
                if (stop) begin
                    state_nxt   = IDLE;
                    counter_nxt = '0;
                end else if (wrap) begin
                    counter_nxt    = '0;
                    step_nxt       = 1'b1;
                    step_count_nxt = step_inc;
                    if ((burst_reg != '0) && (step_inc == burst_reg)) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end else begin
                    counter_nxt = counter + CNT_ONE;
                end
                clock_nxt = (state_nxt == RUN) && (counter < (div_reg >> 1));
            end
            STEP: begin
                step_nxt       = 1'b1;
                step_count_nxt = step_inc;
                state_nxt      = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            counter    <= '0;
            div_reg    <= DEFAULT_DIV;
            burst_reg  <= '0;
            step_count <= '0;
            step_out   <= 1'b0;
            clock_out  <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            counter    <= counter_nxt;
            burst_reg  <= burst_nxt;
            step_count <= step_count_nxt;
            step_out   <= step_nxt;
            clock_out  <= clock_nxt;
            done       <= done_nxt;
            if (div_valid && div_ready)
                div_reg <= (div_value < CNT_TWO) ? CNT_TWO : div_value;
        end
    end

endmodule

// File: tb/tb_led_rate_controller.sv
// Bench for led_rate_controller: vector table, directed run sequences and random traffic against a cycle-count model.
module tb_led_rate_controller;

    logic        clock_in;
    logic        reset;
    logic        start, stop, single_step, div_valid;
    logic [27:0] div_value;
    logic        div_ready;
    logic [15:0] burst_len;
    logic        step_out, clock_out, busy, done;
    logic [15:0] step_count;

    int total = 0;
    int bad   = 0;

    led_rate_controller #(.CNT_W(28), .DEFAULT_DIV(28'd8), .BURST_W(16)) dut (
        .clock_in(clock_in), .reset(reset), .start(start), .stop(stop),
        .single_step(single_step), .div_valid(div_valid), .div_value(div_value),
        .div_ready(div_ready), .burst_len(burst_len), .step_out(step_out),
        .clock_out(clock_out), .busy(busy), .done(done), .step_count(step_count)
    );

    initial begin
        clock_in = 1'b0;
        forever #5 clock_in = ~clock_in;
    end

    // Model: mode 0 idle, 1 running, 2 single step pending; m_t counts edges since start
    int          m_mode, m_t, m_div;
    logic [15:0] m_burst, m_cnt;
    logic        m_step, m_done, m_clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_t = 0; m_div = 8; m_burst = '0; m_cnt = '0;
        m_step = 1'b0; m_done = 1'b0; m_clk = 1'b0;
    endtask

    task automatic model_edge(input logic st, input logic sp, input logic ss, input logic dv,
                              input logic [27:0] dval, input logic [15:0] bl);
        m_step = 1'b0; m_done = 1'b0; m_clk = 1'b0;
        case (m_mode)
            0: begin
                if (dv) m_div = (dval < 28'd2) ? 2 : int'(dval);
                if (st) begin
                    m_mode = 1; m_t = 0; m_burst = bl; m_cnt = '0;
                end else if (ss) begin
                    m_mode = 2;
                end
            end
            1: begin
                if (sp) begin
                    m_mode = 0;
                end else begin
                    m_t++;
                    if (m_t % m_div == 0) begin
                        m_step = 1'b1;
                        m_cnt++;
                        if (m_burst != 16'd0 && m_cnt == m_burst) begin
                            m_mode = 0;
                            m_done = 1'b1;
                        end
                    end
                    if (m_mode == 1) m_clk = ((m_t - 1) % m_div) < (m_div / 2);
                end
            end
            default: begin
                m_step = 1'b1;
                m_cnt++;
                m_mode = 0;
            end
        endcase
    endtask

    task automatic compare_model(input string tag);
        check({tag, "_step"},  int'(step_out),   int'(m_step));
        check({tag, "_done"},  int'(done),       int'(m_done));
        check({tag, "_clk"},   int'(clock_out),  int'(m_clk));
        check({tag, "_busy"},  int'(busy),       int'(m_mode != 0));
        check({tag, "_rdy"},   int'(div_ready),  int'(m_mode == 0));
        check({tag, "_count"}, int'(step_count), int'(m_cnt));
    endtask

    // Called just after a rising edge: drive, clock, then sample one time unit after the edge
    task automatic tick(input logic st, input logic sp, input logic ss, input logic dv,
                        input logic [27:0] dval, input logic [15:0] bl);
        start = st; stop = sp; single_step = ss; div_valid = dv; div_value = dval; burst_len = bl;
        @(posedge clock_in);
        #1;
        model_edge(st, sp, ss, dv, dval, bl);
        compare_model("model");
    endtask

    task automatic idle_tick();
        tick(1'b0, 1'b0, 1'b0, 1'b0, 28'd0, 16'd0);
    endtask

    task automatic do_reset();
        start = 0; stop = 0; single_step = 0; div_valid = 0; div_value = '0; burst_len = '0;
        reset = 1'b1;
        @(posedge clock_in);
        #1;
        reset = 1'b0;
        model_reset();
        check("rst_step",  int'(step_out),   0);
        check("rst_clk",   int'(clock_out),  0);
        check("rst_done",  int'(done),       0);
        check("rst_busy",  int'(busy),       0);
        check("rst_rdy",   int'(div_ready),  1);
        check("rst_count", int'(step_count), 0);
    endtask

    typedef struct packed {
        logic        st, sp, ss, dv;
        logic [27:0] dval;
        logic [15:0] bl;
        logic        e_step, e_clk, e_busy, e_done, e_rdy;
        logic [15:0] e_cnt;
    } vec_t;

    function automatic vec_t mk(input logic st, input logic sp, input logic ss, input logic dv,
                                input logic [27:0] dval, input logic [15:0] bl,
                                input logic e_step, input logic e_clk, input logic e_busy,
                                input logic e_done, input logic e_rdy, input logic [15:0] e_cnt);
        vec_t v;
        v.st = st; v.sp = sp; v.ss = ss; v.dv = dv; v.dval = dval; v.bl = bl;
        v.e_step = e_step; v.e_clk = e_clk; v.e_busy = e_busy;
        v.e_done = e_done; v.e_rdy = e_rdy; v.e_cnt = e_cnt;
        return v;
    endfunction

    vec_t vecs [15];

    initial begin
        reset = 1'b1;
        start = 0; stop = 0; single_step = 0; div_valid = 0; div_value = '0; burst_len = '0;
        model_reset();

        //              st sp ss dv dval  bl    step clk busy done rdy cnt
        vecs[0]  = mk(0, 0, 1, 0, 28'd0, 16'd0, 0, 0, 1, 0, 0, 16'd0);
        vecs[1]  = mk(0, 0, 0, 0, 28'd0, 16'd0, 1, 0, 0, 0, 1, 16'd1);
        vecs[2]  = mk(0, 0, 1, 0, 28'd0, 16'd0, 0, 0, 1, 0, 0, 16'd1);
        vecs[3]  = mk(0, 0, 0, 0, 28'd0, 16'd0, 1, 0, 0, 0, 1, 16'd2);
        vecs[4]  = mk(1, 0, 0, 1, 28'd1, 16'd2, 0, 0, 1, 0, 0, 16'd0);
        vecs[5]  = mk(0, 0, 0, 0, 28'd0, 16'd0, 0, 1, 1, 0, 0, 16'd0);
        vecs[6]  = mk(0, 0, 0, 0, 28'd0, 16'd0, 1, 0, 1, 0, 0, 16'd1);
        vecs[7]  = mk(0, 0, 0, 0, 28'd0, 16'd0, 0, 1, 1, 0, 0, 16'd1);
        vecs[8]  = mk(0, 0, 0, 0, 28'd0, 16'd0, 1, 0, 0, 1, 1, 16'd2);
        vecs[9]  = mk(1, 0, 1, 0, 28'd0, 16'd0, 0, 0, 1, 0, 0, 16'd0);
        vecs[10] = mk(0, 0, 0, 1, 28'd9, 16'd0, 0, 1, 1, 0, 0, 16'd0);
        vecs[11] = mk(0, 0, 0, 1, 28'd9, 16'd0, 1, 0, 1, 0, 0, 16'd1);
        vecs[12] = mk(0, 0, 0, 0, 28'd0, 16'd0, 0, 1, 1, 0, 0, 16'd1);
        vecs[13] = mk(0, 1, 0, 0, 28'd0, 16'd0, 0, 0, 0, 0, 1, 16'd1);
        vecs[14] = mk(0, 0, 0, 0, 28'd0, 16'd0, 0, 0, 0, 0, 1, 16'd1);

        do_reset();
        for (int i = 0; i < 15; i++) begin
            tick(vecs[i].st, vecs[i].sp, vecs[i].ss, vecs[i].dv, vecs[i].dval, vecs[i].bl);
            check($sformatf("vec%0d_step", i),  int'(step_out),   int'(vecs[i].e_step));
            check($sformatf("vec%0d_clk", i),   int'(clock_out),  int'(vecs[i].e_clk));
            check($sformatf("vec%0d_busy", i),  int'(busy),       int'(vecs[i].e_busy));
            check($sformatf("vec%0d_done", i),  int'(done),       int'(vecs[i].e_done));
            check($sformatf("vec%0d_rdy", i),   int'(div_ready),  int'(vecs[i].e_rdy));
            check($sformatf("vec%0d_count", i), int'(step_count), int'(vecs[i].e_cnt));
        end

        // Default divisor of 8, free running: steps at 8/16/24, blink high 4 low 4
        do_reset();
        tick(1'b1, 1'b0, 1'b0, 1'b0, 28'd0, 16'd0);
        for (int k = 1; k <= 24; k++) begin
            idle_tick();
            check($sformatf("d8_step_k%0d", k),  int'(step_out),   int'(k % 8 == 0));
            check($sformatf("d8_clk_k%0d", k),   int'(clock_out),  int'(((k - 1) % 8) < 4));
            check($sformatf("d8_count_k%0d", k), int'(step_count), k / 8);
        end
        tick(1'b0, 1'b1, 1'b0, 1'b0, 28'd0, 16'd0);

        // Divisor 5 loaded on the start edge, burst of 3
        start = 1'b1; div_valid = 1'b1; div_value = 28'd5; burst_len = 16'd3;
        #1;
        check("d5_rdy_on_load", int'(div_ready), 1);
        tick(1'b1, 1'b0, 1'b0, 1'b1, 28'd5, 16'd3);
        for (int k = 1; k <= 15; k++) begin
            idle_tick();
            check($sformatf("d5_step_k%0d", k), int'(step_out), int'(k % 5 == 0));
            check($sformatf("d5_done_k%0d", k), int'(done),     int'(k == 15));
        end
        check("d5_busy_end",  int'(busy),       0);
        check("d5_count_end", int'(step_count), 3);
        idle_tick();
        check("d5_done_once", int'(done), 0);

        // Divisor 4, stop lands on the first wrap edge
        tick(1'b1, 1'b0, 1'b0, 1'b1, 28'd4, 16'd0);
        for (int k = 1; k <= 3; k++) idle_tick();
        tick(1'b0, 1'b1, 1'b0, 1'b0, 28'd0, 16'd0);
        check("stopwrap_step",  int'(step_out),   0);
        check("stopwrap_count", int'(step_count), 0);
        check("stopwrap_done",  int'(done),       0);
        check("stopwrap_busy",  int'(busy),       0);

        // Divisor 6, reset asserted mid-run after two steps
        tick(1'b1, 1'b0, 1'b0, 1'b1, 28'd6, 16'd0);
        for (int k = 1; k <= 13; k++) idle_tick();
        check("pre_rst_count", int'(step_count), 2);
        check("pre_rst_clk",   int'(clock_out),  1);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_clk",   int'(clock_out),  0);
        check("async_rst_busy",  int'(busy),       0);
        check("async_rst_count", int'(step_count), 0);
        check("async_rst_rdy",   int'(div_ready),  1);
        check("async_rst_step",  int'(step_out),   0);
        check("async_rst_done",  int'(done),       0);
        @(posedge clock_in);
        #1;
        reset = 1'b0;
        model_reset();
        tick(1'b1, 1'b0, 1'b0, 1'b0, 28'd0, 16'd1);
        for (int k = 1; k <= 8; k++) begin
            idle_tick();
            check($sformatf("revert_step_k%0d", k), int'(step_out), int'(k == 8));
        end

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            tick(($urandom_range(0, 15) == 0), ($urandom_range(0, 31) == 0),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
                 28'($urandom_range(0, 7)), 16'($urandom_range(0, 4)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
